mod_counter_prescaled: RTL and testbench
========================================

Name: mod_counter_prescaled

Overview:
Parametrised successor to the 74161-style counter plus divider pair. It contains a single-clock-domain prescaler that produces a one-cycle count-enable tick; no derived clocks are generated. It also contains a WIDTH-bit modulo-MODULUS up/down counter with synchronous load, synchronous clear and 74161-compatible enp/ent/rco cascading. It sits directly on the board clock and drives display or timer chains.

Parameters:
WIDTH, 4, counter width in bits
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH
DIV_RATIO, 50000000, board-clock cycles per count tick; 1 means tick every cycle
DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= DIV_RATIO

Ports:
clk_50mhz  input  1  board clock; all state on rising edge
clrn  input  1  asynchronous active-low reset/clear of all state
sclrn  input  1  synchronous active-low clear of counter (not prescaler)
ldn  input  1  synchronous active-low parallel load
enp  input  1  count enable (parallel)
ent  input  1  count enable (trickle); also gates rco
up  input  1  1 = count up, 0 = count down
data_in  input  WIDTH  load value
q_out  output  WIDTH  counter value
rco  output  1  ripple carry: ent & terminal count
tc_pulse  output  1  one-cycle pulse on the cycle the counter wraps
tick  output  1  registered prescaler tick, one clk_50mhz cycle wide

Behaviour:
- Reset (clrn=0, asynchronous): prescaler=0, tick=0, q_out=0. rco and tc_pulse follow combinationally; with up=1 both are 0.
- Prescaler: counts 0..DIV_RATIO-1 and wraps. tick is registered high for exactly the cycle after the prescaler reaches DIV_RATIO-1.
  - First tick occurs DIV_RATIO cycles after reset release.
  - DIV_RATIO=1: tick=1 every cycle after the first post-reset edge.
  - Prescaler is free-running; sclrn, ldn and enables do not affect it.
- Counter next-state priority per clk_50mhz edge, highest first:
  1. sclrn=0 -> q_out=0. Acts on any edge, not tick-gated.
  2. ldn=0 -> q_out=data_in. Acts on any edge, not tick-gated. If data_in >= MODULUS, q_out=MODULUS-1.
  3. tick & enp & ent -> count:
     - up=1: q_out = (q_out==MODULUS-1) ? 0 : q_out+1
     - up=0: q_out = (q_out==0) ? MODULUS-1 : q_out-1
  4. Otherwise hold.
- Terminal count: up=1 -> q_out==MODULUS-1; up=0 -> q_out==0.
- rco = ent & terminal. Combinational, independent of enp and tick (74161 semantics); allows ent-chained cascading.
- tc_pulse = tick & enp & ent & terminal & sclrn & ldn. High exactly on the edge where a wrap is committed. Cascaded stages use it as their enp.
- Direction change takes effect on the next tick; no glitch is introduced into q_out.
- q_out is never outside 0..MODULUS-1 after any edge.
- clrn asserted mid-count: immediate clear; counting resumes DIV_RATIO cycles after release.
- sclrn and ldn both low: clear wins.

Decomposition:
- Shared package counter_pkg holds direction constants (DIR_UP=1, DIR_DOWN=0) and a clog2-based helper for DIV_W/WIDTH defaults.
- One sub-module: tick_prescaler (parameter DIV_RATIO, ports clk_50mhz, clrn, tick). It is reusable for the 1 kHz/100 Hz/10 Hz enables elsewhere.
- Counter next-state logic stays in mod_counter_prescaled.

Test Plan:
- Reset/tick: WIDTH=4, MODULUS=10, DIV_RATIO=4; release clrn -> tick high on cycles 4, 8, 12, ...; q_out=0 until the first tick, then 1.
- Up wrap: enp=ent=up=1 from q_out=0 -> sequence 0..9,0. At q_out=9: rco=1 continuously; tc_pulse=1 only on the tick cycle; q_out becomes 0 on that edge.
- Down wrap and rco gating: up=0 from q_out=0 -> 9,8,...; ent=0 at q_out=0 -> rco=0, no count. enp=0, ent=1 at q_out=0 -> rco=1, tc_pulse=0, hold.
- Load/clear priority: ldn=0 with data_in=7 on a non-tick cycle -> q_out=7 next edge. data_in=12 -> q_out=9. sclrn=0 and ldn=0 together -> q_out=0.
- Async reset mid-count: q_out=5, clrn pulsed low between edges -> q_out=0 immediately; next tick 4 cycles after release.
- Cascade/DIV_RATIO=1: two instances, second enp driven by first tc_pulse, both ent=1, MODULUS=10 -> combined value 00..99 in 100 cycles, then 00; second stage increments only when first goes 9->0.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the prescaled modulo counter family.
//   DIR_UP / DIR_DOWN : encoding of the counter 'up' input
//   bits_for(n)       : bits needed to hold 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A divide-by-1 or divide-by-2 prescaler still needs a 1-bit register.
    function automatic int bits_for(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divide-by-DIV_RATIO counter that emits a registered one-cycle
// enable tick. No clock is derived; consumers qualify logic with 'tick'.
// Ports:
//   clk_50mhz : in  board clock, rising edge
//   clrn      : in  asynchronous active-low reset
//   tick      : out high for one cycle every DIV_RATIO cycles; the first tick
//                   appears DIV_RATIO cycles after clrn release
// -----------------------------------------------------------------------------
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV_RATIO = 50000000,
    parameter int DIV_W     = bits_for(DIV_RATIO)
) (
    input  logic clk_50mhz,
    input  logic clrn,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_RATIO - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + DIV_W'(1);
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz or negedge clrn) begin
        if (!clrn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : tick_prescaler

// File: rtl/mod_counter_prescaled.sv
// -----------------------------------------------------------------------------
// mod_counter_prescaled
// Modulo-MODULUS up/down counter advanced by an internal prescaler tick, with
// 74161-style enp/ent/rco cascading.
// Ports:
//   clk_50mhz : in  board clock, rising edge
//   clrn      : in  asynchronous active-low reset of counter and prescaler
//   sclrn     : in  synchronous active-low clear of the counter (highest prio)
//   ldn       : in  synchronous active-low load of data_in (clamped)
//   enp, ent  : in  count enables; ent also gates rco
//   up        : in  1 = count up, 0 = count down
//   data_in   : in  load value
//   q_out     : out counter value, always within 0..MODULUS-1
//   rco       : out ent & terminal count (combinational)
//   tc_pulse  : out high on the cycle whose edge commits a wrap
//   tick      : out prescaler tick
// -----------------------------------------------------------------------------
module mod_counter_prescaled
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int DIV_RATIO = 50000000,
    parameter int DIV_W     = bits_for(DIV_RATIO)
) (
    input  logic             clk_50mhz,
    input  logic             clrn,
    input  logic             sclrn,
    input  logic             ldn,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q_out,
    output logic             rco,
    output logic             tc_pulse,
    output logic             tick
);

    // One extra bit so MODULUS == 2^WIDTH is representable in the clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             terminal;
    logic             count_en;

    tick_prescaler #(
        .DIV_RATIO (DIV_RATIO),
        .DIV_W     (DIV_W)
    ) u_prescaler (
        .clk_50mhz (clk_50mhz),
        .clrn      (clrn),
        .tick      (tick)
    );

    assign terminal = (up == DIR_UP) ? (q_q == Q_MAX) : (q_q == '0);
    assign count_en = tick & enp & ent;

    always_comb begin
        q_d = q_q;
        if (!sclrn) begin
            q_d = '0;
        end else if (!ldn) begin
            q_d = ({1'b0, data_in} >= MOD_EXT) ? Q_MAX : data_in;
        end else if (count_en) begin
            if (up == DIR_UP) begin
                q_d = (q_q == Q_MAX) ? '0 : q_q + WIDTH'(1);
            end else begin
                q_d = (q_q == '0) ? Q_MAX : q_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge clrn) begin
        if (!clrn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out    = q_q;
    assign rco      = ent & terminal;
    // A clear or load overrides the count, so no wrap is committed then.
    assign tc_pulse = count_en & terminal & sclrn & ldn;

endmodule : mod_counter_prescaled

// File: tb/tb_mod_counter_prescaled.sv
module tb_mod_counter_prescaled;

    logic       clk;
    logic       clrn, sclrn, ldn, enp, ent, up;
    logic [3:0] data_in;
    logic [3:0] q_out;
    logic       rco, tc, tick;

    logic       clrn_c;
    logic [3:0] q0, q1;
    logic       rco0, tc0, tick0, rco1, tc1, tick1;

    int vectors;
    int miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mod_counter_prescaled #(
        .WIDTH(4), .MODULUS(10), .DIV_RATIO(4), .DIV_W(2)
    ) dut (
        .clk_50mhz(clk), .clrn(clrn), .sclrn(sclrn), .ldn(ldn),
        .enp(enp), .ent(ent), .up(up), .data_in(data_in),
        .q_out(q_out), .rco(rco), .tc_pulse(tc), .tick(tick)
    );

    mod_counter_prescaled #(
        .WIDTH(4), .MODULUS(10), .DIV_RATIO(1), .DIV_W(1)
    ) c0 (
        .clk_50mhz(clk), .clrn(clrn_c), .sclrn(1'b1), .ldn(1'b1),
        .enp(1'b1), .ent(1'b1), .up(1'b1), .data_in(4'd0),
        .q_out(q0), .rco(rco0), .tc_pulse(tc0), .tick(tick0)
    );

    mod_counter_prescaled #(
        .WIDTH(4), .MODULUS(10), .DIV_RATIO(1), .DIV_W(1)
    ) c1 (
        .clk_50mhz(clk), .clrn(clrn_c), .sclrn(1'b1), .ldn(1'b1),
        .enp(tc0), .ent(1'b1), .up(1'b1), .data_in(4'd0),
        .q_out(q1), .rco(rco1), .tc_pulse(tc1), .tick(tick1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then settle a little.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int eq;
        vectors     = 0;
        miscompares = 0;
        clrn = 1'b0; clrn_c = 1'b0;
        sclrn = 1'b1; ldn = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
        data_in = 4'd0;

        nxt(); nxt();
        check("rst_q",    32'(q_out), 32'd0);
        check("rst_tick", 32'(tick),  32'd0);
        check("rst_rco",  32'(rco),   32'd0);
        check("rst_tc",   32'(tc),    32'd0);

        clrn = 1'b1;
        #1;
        check("rel_tick", 32'(tick),  32'd0);
        check("rel_q",    32'(q_out), 32'd0);

        // Ticks after edges 4,8,...; counts land on edges 5,9,...; wrap at edge 41.
        for (int k = 1; k <= 41; k++) begin
            nxt();
            eq = ((k - 1) / 4) % 10;
            check("tick",   32'(tick),  32'(k % 4 == 0));
            check("q_up",   32'(q_out), 32'(eq));
            check("rco_up", 32'(rco),   32'(eq == 9));
            check("tc_up",  32'(tc),    32'((eq == 9) && (k % 4 == 0)));
        end

        // Count down from 0: tick after edge 44, wrap to 9 at edge 45.
        up = 1'b0;
        #1;
        check("dn_rco0", 32'(rco), 32'd1);
        check("dn_tc0",  32'(tc),  32'd0);
        for (int k = 42; k <= 49; k++) begin
            nxt();
            eq = (k < 45) ? 0 : ((k < 49) ? 9 : 8);
            check("q_dn",   32'(q_out), 32'(eq));
            check("rco_dn", 32'(rco),   32'(k < 45));
            check("tc_dn",  32'(tc),    32'(k == 44));
        end

        // Loads on non-tick edges, clamping, clear over load.
        ldn = 1'b0; data_in = 4'd7;
        nxt();
        check("load7", 32'(q_out), 32'd7);
        data_in = 4'd12;
        nxt();
        check("load12_clamp", 32'(q_out), 32'd9);
        data_in = 4'd15;
        nxt();
        check("load15_clamp", 32'(q_out), 32'd9);
        sclrn = 1'b0; data_in = 4'd5;
        nxt();
        check("clr_over_ld", 32'(q_out), 32'd0);
        sclrn = 1'b1; ldn = 1'b1;

        // ent=0 at q=0 counting down: no rco, no count.
        ent = 1'b0;
        #1;
        check("ent0_rco", 32'(rco), 32'd0);
        nxt(); nxt(); nxt();
        check("ent0_tick", 32'(tick), 32'd1);
        check("ent0_tc",   32'(tc),   32'd0);
        check("ent0_rco2", 32'(rco),  32'd0);
        nxt();
        check("ent0_hold", 32'(q_out), 32'd0);

        // enp=0, ent=1: rco still asserted, tc_pulse suppressed, hold.
        enp = 1'b0; ent = 1'b1;
        #1;
        check("enp0_rco", 32'(rco), 32'd1);
        check("enp0_tc",  32'(tc),  32'd0);
        nxt(); nxt(); nxt();
        check("enp0_tick", 32'(tick), 32'd1);
        check("enp0_tc2",  32'(tc),   32'd0);
        check("enp0_rco2", 32'(rco),  32'd1);
        nxt();
        check("enp0_hold", 32'(q_out), 32'd0);

        // Both enables: tc_pulse on tick, masked by a pending load.
        enp = 1'b1;
        nxt(); nxt(); nxt();
        check("tc_dn_wrap", 32'(tc), 32'd1);
        ldn = 1'b0; data_in = 4'd3;
        #1;
        check("tc_ld_mask", 32'(tc), 32'd0);
        ldn = 1'b1;
        #1;
        check("tc_unmask", 32'(tc), 32'd1);
        nxt();
        check("dn_wrap_q", 32'(q_out), 32'd9);

        // Async reset mid-count.
        up = 1'b1; ldn = 1'b0; data_in = 4'd5;
        nxt();
        ldn = 1'b1;
        check("pre_async_q", 32'(q_out), 32'd5);
        clrn = 1'b0;
        #1;
        check("async_q",    32'(q_out), 32'd0);
        check("async_tick", 32'(tick),  32'd0);
        #1;
        clrn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            nxt();
            check("post_rst_tick", 32'(tick),  32'(k == 4));
            check("post_rst_q",    32'(q_out), 32'(k == 5));
        end

        // Two-stage cascade, divide-by-1 prescaler.
        clrn_c = 1'b1;
        #1;
        check("casc_rel", 32'(10 * q1 + q0), 32'd0);
        check("casc_tick0", 32'(tick0), 32'd0);
        for (int k = 1; k <= 101; k++) begin
            nxt();
            check("cascade", 32'(10 * int'(q1) + int'(q0)), 32'((k - 1) % 100));
            if (k == 10 || k == 100) begin
                check("casc_tc0", 32'(tc0), 32'd1);
            end
        end
        check("casc_tc1_after", 32'(tc1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mod_counter_prescaled
